// File: rtl/cam_reg_seq.sv
// Camera register-table sequencer: walks an external {addr,data} LUT and issues SCCB writes,
// with NACK retry, millisecond delay entries and done/error reporting.
module cam_reg_seq #(
  parameter logic [7:0]        DEV_ADDR     = 8'hC0,
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                NUM_REGS     = 126,
  parameter int                IDX_W        = 9,
  parameter int                MAX_RETRY    = 3,
  parameter logic [ADDR_W-1:0] DELAY_TAG    = {ADDR_W{1'b1}},
  parameter int                TICKS_PER_MS = 20
) (
  input  logic                       clk_20k,
  input  logic                       camera_rstn,
  input  logic                       cfg_req,
  output logic [IDX_W-1:0]           reg_index,
  input  logic [ADDR_W+DATA_W-1:0]   lut_data,
  output logic [8+ADDR_W+DATA_W-1:0] i2c_data,
  output logic                       i2c_start,
  input  logic                       i2c_tr_end,
  input  logic                       i2c_nack,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic [IDX_W-1:0]           err_index
);

  localparam logic [2:0] S_LOAD     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_END = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DELAY    = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_FAIL     = 3'd7;

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  // Sized so that the largest data value times TICKS_PER_MS still fits.
  localparam int DLY_W = DATA_W + $clog2(TICKS_PER_MS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [DLY_W-1:0] TICKS    = DLY_W'(TICKS_PER_MS);

  logic [2:0]        state;
  logic              load_ph;
  logic [RTY_W-1:0]  retry_cnt;
  logic [DLY_W-1:0]  dly_cnt;

  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_val;
  logic              is_delay;
  logic [DLY_W-1:0]  dly_load;
  logic              last_entry;

  assign lut_addr   = lut_data[ADDR_W+DATA_W-1:DATA_W];
  assign lut_val    = lut_data[DATA_W-1:0];
  assign is_delay   = (lut_addr == DELAY_TAG);
  assign dly_load   = DLY_W'(lut_val) * TICKS;
  assign last_entry = (reg_index == LAST_IDX);

  // i2c_start is registered and raised on entry to ISSUE together with the data latch,
  // so the engine never sees a start with stale data and a retry gap is exactly GAP.
  always_ff @(posedge clk_20k or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state     <= S_LOAD;
      load_ph   <= 1'b0;
      reg_index <= '0;
      retry_cnt <= '0;
      dly_cnt   <= '0;
      i2c_data  <= '0;
      i2c_start <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!load_ph) begin
            load_ph <= 1'b1;
          end else begin
            load_ph <= 1'b0;
            if (is_delay) begin
              dly_cnt <= dly_load;
              state   <= S_DELAY;
            end else begin
              i2c_data  <= {DEV_ADDR, lut_data};
              i2c_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          state <= S_WAIT_END;
        end

        S_WAIT_END: begin
          if (i2c_tr_end) begin
            i2c_start <= 1'b0;
            if (!i2c_nack) begin
              state <= S_NEXT;
            end else if (retry_cnt < RTY_MAX) begin
              retry_cnt <= retry_cnt + RTY_W'(1);
              state     <= S_GAP;
            end else begin
              cfg_err   <= 1'b1;
              err_index <= reg_index;
              state     <= S_FAIL;
            end
          end
        end

        S_GAP: begin
          i2c_start <= 1'b1;
          state     <= S_ISSUE;
        end

        // Dwell for data*TICKS_PER_MS cycles; a zero delay still spends one cycle here.
        S_DELAY: begin
          if (dly_cnt <= DLY_W'(1)) begin
            dly_cnt <= '0;
            state   <= S_NEXT;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end

        S_NEXT: begin
          retry_cnt <= '0;
          if (last_entry) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            reg_index <= reg_index + IDX_W'(1);
            state     <= S_LOAD;
          end
        end

        S_DONE: begin
          if (cfg_req) begin
            cfg_done  <= 1'b0;
            reg_index <= '0;
            retry_cnt <= '0;
            state     <= S_LOAD;
          end
        end

        S_FAIL: begin
          if (cfg_req) begin
            cfg_err   <= 1'b0;
            reg_index <= '0;
            retry_cnt <= '0;
            state     <= S_LOAD;
          end
        end

        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_reg_seq.sv
// Randomized scoreboard bench for cam_reg_seq: a table-level model predicts every SCCB write,
// a monitor compares each start pulse against the prediction.
module tb_cam_reg_seq;
  localparam int NREG      = 4;
  localparam int IDX_W     = 9;
  localparam int MAX_RETRY = 3;

  logic             clk_20k = 1'b0;
  logic             camera_rstn = 1'b0;
  logic             cfg_req = 1'b0;
  logic             i2c_tr_end = 1'b0;
  logic             i2c_nack = 1'b0;
  logic [IDX_W-1:0] reg_index;
  logic [IDX_W-1:0] err_index;
  logic [23:0]      lut_data;
  logic [31:0]      i2c_data;
  logic             i2c_start;
  logic             cfg_done;
  logic             cfg_err;

  always #5 clk_20k = ~clk_20k;

  cam_reg_seq #(
    .DEV_ADDR(8'hC0), .ADDR_W(16), .DATA_W(8), .NUM_REGS(NREG), .IDX_W(IDX_W),
    .MAX_RETRY(MAX_RETRY), .DELAY_TAG(16'hFFFF), .TICKS_PER_MS(20)
  ) dut (
    .clk_20k(clk_20k), .camera_rstn(camera_rstn), .cfg_req(cfg_req),
    .reg_index(reg_index), .lut_data(lut_data), .i2c_data(i2c_data),
    .i2c_start(i2c_start), .i2c_tr_end(i2c_tr_end), .i2c_nack(i2c_nack),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        retry;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] table_mem [NREG];
  int          nack_plan [NREG];
  int          attempts  [NREG];
  int          eng_lat = 10;
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: one write per attempt, delay entries produce none, stop at a dead entry.
  task automatic expect_pass(output bit ok, output int fidx);
    exp_t e;
    int   tries;
    ok   = 1'b1;
    fidx = 0;
    for (int i = 0; i < NREG; i++) begin
      if (table_mem[i][23:8] != 16'hFFFF) begin
        tries = (nack_plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_plan[i] + 1;
        for (int t = 0; t < tries; t++) begin
          e.dat   = {8'hC0, table_mem[i]};
          e.retry = (t > 0);
          exp_q.push_back(e);
        end
        if (nack_plan[i] > MAX_RETRY) begin
          ok   = 1'b0;
          fidx = i;
          break;
        end
      end
    end
  endtask

  task automatic finish_pass(input string tag, input bit ok, input int fidx);
    bit got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_20k);
      if (cfg_done || cfg_err) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, got, 1);
    repeat (6) @(negedge clk_20k);
    check({tag, "_done"}, cfg_done, ok);
    check({tag, "_err"}, cfg_err, !ok);
    if (ok) check({tag, "_last_index"}, reg_index, NREG - 1);
    else    check({tag, "_err_index"}, err_index, fidx);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic clear_attempts;
    for (int i = 0; i < NREG; i++) attempts[i] = 0;
  endtask

  task automatic apply_reset;
    @(posedge clk_20k); #2;
    camera_rstn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk_20k);
    #2;
    clear_attempts();
    camera_rstn = 1'b1;
  endtask

  task automatic pulse_cfg_req;
    @(posedge clk_20k); #2;
    cfg_req = 1'b1;
    @(posedge clk_20k); #2;
    cfg_req = 1'b0;
  endtask

  task automatic plain_table;
    for (int i = 0; i < NREG; i++) begin
      table_mem[i] = {16'($urandom_range(0, 65534)), 8'($urandom)};
      nack_plan[i] = 0;
    end
  endtask

  // LUT: garbage for the first cycle after an index change, real entry after that.
  initial begin
    int prev = 0;
    forever begin
      @(posedge clk_20k); #1;
      if (!camera_rstn || int'(reg_index) == prev) lut_data = table_mem[reg_index[1:0]];
      else                                         lut_data = 24'($urandom);
      prev = int'(reg_index);
    end
  end

  // I2C engine: answers a start after eng_lat cycles, NACKs per plan, stray tr_end when idle.
  initial begin
    int cnt = 0;
    int idx;
    forever begin
      @(posedge clk_20k); #1;
      i2c_tr_end = 1'b0;
      i2c_nack   = 1'b0;
      if (camera_rstn && i2c_start) begin
        cnt++;
        if (cnt >= eng_lat) begin
          idx        = int'(reg_index[1:0]);
          i2c_tr_end = 1'b1;
          i2c_nack   = (attempts[idx] < nack_plan[idx]);
          attempts[idx]++;
          cnt = 0;
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 5) == 0) begin
          i2c_tr_end = 1'b1;
          i2c_nack   = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: every rising start is matched against the next predicted write.
  initial begin
    bit   prev = 1'b0;
    int   low  = 0;
    exp_t e;
    forever begin
      @(negedge clk_20k);
      if (camera_rstn) begin
        check("done_err_exclusive", cfg_done & cfg_err, 0);
        check("index_in_range", reg_index < NREG, 1);
        if (i2c_start && !prev) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_start: got data %h at index %0d, expected no write", i2c_data, reg_index);
          end else begin
            e = exp_q.pop_front();
            check("i2c_data", i2c_data, e.dat);
            check("flags_low_while_writing", {cfg_done, cfg_err}, 0);
            if (e.retry) check("retry_gap_cycles", low, 1);
          end
        end
      end
      if (i2c_start) low = 0;
      else           low++;
      prev = i2c_start;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int fidx;
    int dur;
    bit seen;

    for (int i = 0; i < NREG; i++) begin
      table_mem[i] = '0;
      nack_plan[i] = 0;
      attempts[i]  = 0;
    end

    // Reset values
    repeat (2) @(posedge clk_20k);
    #2;
    check("rst_index", reg_index, 0);
    check("rst_start", i2c_start, 0);
    check("rst_data", i2c_data, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_err_index", err_index, 0);

    // All entries ACK, 10-cycle transfers
    plain_table();
    eng_lat = 10;
    apply_reset();
    expect_pass(ok, fidx);
    finish_pass("all_ack", ok, fidx);

    // Entry 1 NACKs twice, then ACKs
    plain_table();
    nack_plan[1] = 2;
    eng_lat = 4;
    apply_reset();
    expect_pass(ok, fidx);
    finish_pass("retry", ok, fidx);

    // Entry 2 never ACKs; then restart via cfg_req with a healthy engine
    plain_table();
    nack_plan[2] = 99;
    eng_lat = 5;
    apply_reset();
    expect_pass(ok, fidx);
    finish_pass("dead_entry", ok, fidx);
    nack_plan[2] = 0;
    clear_attempts();
    expect_pass(ok, fidx);
    pulse_cfg_req();
    check("fail_clear_err", cfg_err, 0);
    check("fail_clear_index", reg_index, 0);
    finish_pass("after_fail", ok, fidx);

    // Entry 1 is a 5 ms delay
    plain_table();
    table_mem[1] = {16'hFFFF, 8'h05};
    eng_lat = 3;
    apply_reset();
    expect_pass(ok, fidx);
    for (int c = 0; c < 2000 && reg_index != 1; c++) @(negedge clk_20k);
    dur = 0;
    while (reg_index == 1 && dur < 400) begin
      @(negedge clk_20k);
      dur++;
    end
    tests++;
    if (dur < 100 || dur > 104) begin
      fails++;
      $display("FAIL delay_window: index 1 held %0d cycles, expected 100..104", dur);
    end
    finish_pass("delay", ok, fidx);

    // Reset while entry 3 is in flight
    plain_table();
    eng_lat = 10;
    apply_reset();
    expect_pass(ok, fidx);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_20k);
      if (reg_index == 3 && i2c_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_entry3", seen, 1);
    repeat (3) @(posedge clk_20k);
    #2;
    camera_rstn = 1'b0;
    #1;
    check("midrst_start", i2c_start, 0);
    check("midrst_index", reg_index, 0);
    check("midrst_data", i2c_data, 0);
    check("midrst_done", cfg_done, 0);
    check("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk_20k);
    #2;
    clear_attempts();
    camera_rstn = 1'b1;
    expect_pass(ok, fidx);
    finish_pass("after_reset", ok, fidx);

    // cfg_req during a transfer is ignored; after DONE it starts a second pass
    plain_table();
    eng_lat = 10;
    apply_reset();
    expect_pass(ok, fidx);
    for (int c = 0; c < 200 && !i2c_start; c++) @(negedge clk_20k);
    pulse_cfg_req();
    finish_pass("req_ignored", ok, fidx);
    clear_attempts();
    expect_pass(ok, fidx);
    pulse_cfg_req();
    check("second_pass_done_low", cfg_done, 0);
    finish_pass("second_pass", ok, fidx);

    // Random tables: delays, retries, occasional dead entries
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREG; i++) begin
        if ($urandom_range(0, 3) == 0) table_mem[i] = {16'hFFFF, 8'($urandom_range(0, 2))};
        else                           table_mem[i] = {16'($urandom_range(0, 65534)), 8'($urandom)};
        nack_plan[i] = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, 2);
      end
      eng_lat = $urandom_range(2, 8);
      apply_reset();
      expect_pass(ok, fidx);
      finish_pass("random", ok, fidx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_reg_seq.md
CAM_REG_SEQ -- requirements
Module: cam_reg_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'hC0, SCCB write device address.
REQ-002 SHALL have parameter ADDR_W, default 16, register address width.
REQ-003 SHALL have parameter DATA_W, default 8, register data width.
REQ-004 SHALL have parameter NUM_REGS, default 126, table entries (>=1).
REQ-005 SHALL have parameter IDX_W, default 9, index width (2^IDX_W >= NUM_REGS).
REQ-006 SHALL have parameter MAX_RETRY, default 3, retries per entry after NACK.
REQ-007 SHALL have parameter DELAY_TAG, default all-ones ADDR_W, address marking a delay entry.
REQ-008 SHALL have parameter TICKS_PER_MS, default 20, clk_20k cycles per millisecond.
REQ-009 clk_20k  input  1  sequencer clock; all logic on rising edge.
REQ-010 camera_rstn  input  1  reset, asynchronous, active-low.
REQ-011 cfg_req  input  1  restart request, sampled only in DONE or FAIL.
REQ-012 reg_index  output  IDX_W  table index presented to external LUT.
REQ-013 lut_data  input  ADDR_W+DATA_W  {address,data} for reg_index, valid one cycle after index change.
REQ-014 i2c_data  output  8+ADDR_W+DATA_W  {DEV_ADDR,lut_data} to I2C engine.
REQ-015 i2c_start  output  1  level request to I2C engine.
REQ-016 i2c_tr_end  input  1  transfer complete from I2C engine.
REQ-017 i2c_nack  input  1  NACK seen, valid when i2c_tr_end=1.
REQ-018 cfg_done  output  1  whole table written.
REQ-019 cfg_err  output  1  entry failed after all retries.
REQ-020 err_index  output  IDX_W  index of failing entry.

Function
REQ-021 SHALL implement FSM states LOAD, ISSUE, WAIT_END, GAP, DELAY, NEXT, DONE, FAIL.
REQ-022 LOAD: one wait cycle for LUT; then if lut_data address == DELAY_TAG -> DELAY, else -> ISSUE.
REQ-023 ISSUE: latch i2c_data={DEV_ADDR,lut_data}, assert i2c_start -> WAIT_END.
REQ-024 WAIT_END: on i2c_tr_end deassert i2c_start; nack=0 -> NEXT; nack=1 and retry_cnt<MAX_RETRY -> retry_cnt+1, GAP; nack=1 and retry_cnt==MAX_RETRY -> FAIL.
REQ-025 GAP: i2c_start low exactly one cycle, i2c_data held -> ISSUE.
REQ-026 DELAY: load counter = data*TICKS_PER_MS, decrement each cycle, -> NEXT on count 0; data 0 -> NEXT next cycle; no I2C activity.
REQ-027 NEXT: reg_index==NUM_REGS-1 -> DONE; else reg_index+1, retry_cnt=0 -> LOAD.
REQ-028 DONE: cfg_done=1 held; cfg_req=1 -> reg_index=0, retry_cnt=0, cfg_done=0 -> LOAD.
REQ-029 FAIL: cfg_err=1, err_index=reg_index, both held; cfg_req=1 -> clear cfg_err, reg_index=0 -> LOAD.
REQ-030 cfg_req SHALL be ignored in all states except DONE and FAIL.
REQ-031 i2c_tr_end outside WAIT_END SHALL be ignored.
REQ-032 Delay counter width SHALL hold DATA_W max times TICKS_PER_MS without overflow.
REQ-033 reg_index SHALL never exceed NUM_REGS-1.
REQ-034 cfg_done and cfg_err SHALL never be 1 simultaneously.

Reset
REQ-035 camera_rstn low SHALL force state LOAD, reg_index=0, retry_cnt=0, i2c_start=0, i2c_data=0, cfg_done=0, cfg_err=0, err_index=0, delay counter 0.
REQ-036 Reset mid-transfer SHALL drop i2c_start immediately; sequence restarts at index 0 after release.
REQ-037 After release, sequencing SHALL start automatically without cfg_req.

Verification
REQ-038 NUM_REGS=4, all ACK, tr_end 10 cycles after start -> 4 writes, i2c_data[31:24]=8'hC0, cfg_done=1, reg_index=3.
REQ-039 Entry 1 NACK twice then ACK, MAX_RETRY=3 -> three start pulses for entry 1, one-cycle low gap each, cfg_done=1, cfg_err=0.
REQ-040 Entry 2 NACK always -> 4 attempts, cfg_err=1, err_index=2, cfg_done=0; cfg_req -> err cleared, restart at index 0.
REQ-041 Entry 1 = {16'hFFFF,8'h05} -> no start for entry 1, 100 cycles before entry 2 LOAD.
REQ-042 Reset asserted in WAIT_END of entry 3 -> i2c_start=0 same cycle, all outputs reset, restart writes entry 0.
REQ-043 cfg_req pulsed during WAIT_END -> ignored; after DONE, cfg_req -> full second pass, cfg_done low during pass.
